// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports, one write port, $0 tied to zero.
// After reset a sequencer zeroes entries 1..NREGS-1; define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              busy_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];
    logic              wr_acc;

    assign wr_acc = (state_q == ST_READY) && !rst && we_i && (waddr_i != '0);

    // rst is folded into the next-state logic, so the flops below need no reset branch.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_d     = mem_q;
        if (rst) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = ONE;
        end else if (state_q == ST_CLEAR) begin
            mem_d[clr_cnt_q] = '0;
            if (clr_cnt_q == LAST_IDX) begin
                state_d = ST_READY;
            end else begin
                clr_cnt_d = clr_cnt_q + ONE;
            end
        end else if (wr_acc) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_cnt_q <= clr_cnt_d;
        mem_q     <= mem_d;
    end

    assign busy_o = (state_q == ST_CLEAR);

    always_comb begin
        rdata1_o = '0;
        if (rst || busy_o || !re1_i || (raddr1_i == '0)) begin
            rdata1_o = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_acc && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
`endif
        end else begin
            rdata1_o = mem_q[raddr1_i];
        end
    end

    always_comb begin
        rdata2_o = '0;
        if (rst || busy_o || !re2_i || (raddr2_i == '0)) begin
            rdata2_o = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_acc && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
`endif
        end else begin
            rdata2_o = mem_q[raddr2_i];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: clear sequencing, write/read, $0, bypass, writes during clear, reset mid-clear.
// Expected bypass-dependent values follow REGFILE_BYPASS_EN.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        re1_i;
    logic [4:0]  raddr1_i;
    logic [31:0] rdata1_o;
    logic        re2_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata2_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs[12];

    regfile #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we_i),
        .waddr_i  (waddr_i),
        .wdata_i  (wdata_i),
        .re1_i    (re1_i),
        .raddr1_i (raddr1_i),
        .rdata1_o (rdata1_o),
        .re2_i    (re2_i),
        .raddr2_i (raddr2_i),
        .rdata2_o (rdata2_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts cycles with busy_o high, reading through both ports each cycle; bounded at 40.
    task automatic wait_clear(input string name, input bit wr_during, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_o) break;
            we_i     = wr_during;
            waddr_i  = 5'd3;
            wdata_i  = 32'h55;
            re1_i    = 1'b1;
            raddr1_i = 5'((i % 31) + 1);
            re2_i    = 1'b1;
            raddr2_i = 5'd3;
            #1;
            check($sformatf("%s_rd1_c%0d", name, i), rdata1_o, 32'h0);
            check($sformatf("%s_rd2_c%0d", name, i), rdata2_o, 32'h0);
            n++;
            step();
        end
        we_i = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        re1_i = 1'b0; raddr1_i = '0; re2_i = 1'b0; raddr2_i = '0;

        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  1'b1, 5'd5,
                     BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  1'b1, 5'd5,  32'h0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0, 32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0, 32'h0};
        vecs[5]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd1,  1'b1, 5'd3,  32'h0, 32'h33};
        vecs[6]  = '{1'b1, 5'd7,  32'h22,       1'b1, 5'd7,  1'b1, 5'd7,
                     BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'h22, 32'h22};
        vecs[8]  = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd5,  1'b1, 5'd7,  32'hDEADBEEF, 32'h22};
        vecs[9]  = '{1'b1, 5'd10, 32'hA5A5,     1'b1, 5'd9,  1'b1, 5'd10,
                     32'h99, BYP ? 32'hA5A5 : 32'h0};
        vecs[10] = '{1'b1, 5'd20, 32'h2020,     1'b1, 5'd10, 1'b1, 5'd9,  32'hA5A5, 32'h99};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 1'b1, 5'd3,  32'h2020, 32'h33};

        // Reset state
        step();
        step();
        re1_i = 1'b1; raddr1_i = 5'd5;
        #1;
        check("rst_busy", 32'(busy_o), 32'h1);
        check("rst_rd1", rdata1_o, 32'h0);

        // Clear sequence with r3 writes issued on every clear cycle, including the last
        rst = 1'b0;
        wait_clear("clear1", 1'b1, n);
        check("clear1_busy_cycles", n, 31);
        #1;
        for (int a = 1; a < 32; a++) begin
            re1_i = 1'b1; raddr1_i = 5'(a);
            re2_i = 1'b1; raddr2_i = 5'(a);
            #1;
            check($sformatf("post_clear_rd1_r%0d", a), rdata1_o, 32'h0);
            check($sformatf("post_clear_rd2_r%0d", a), rdata2_o, 32'h0);
        end

        // First READY edge accepts a write
        we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h33;
        re1_i = 1'b1; raddr1_i = 5'd3;
        #1;
        check("first_wr_same_cycle", rdata1_o, BYP ? 32'h33 : 32'h0);
        step();
        we_i = 1'b0;
        #1;
        check("first_wr_next_cycle", rdata1_o, 32'h33);

        for (int i = 0; i < 12; i++) begin
            we_i = vecs[i].we; waddr_i = vecs[i].waddr; wdata_i = vecs[i].wdata;
            re1_i = vecs[i].re1; raddr1_i = vecs[i].ra1;
            re2_i = vecs[i].re2; raddr2_i = vecs[i].ra2;
            #1;
            check($sformatf("vec%0d_rd1", i), rdata1_o, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), rdata2_o, vecs[i].e2);
            check($sformatf("vec%0d_busy", i), 32'(busy_o), 32'h0);
            step();
        end
        we_i = 1'b0;

        // Reset from READY, then reset again 10 cycles into the clear
        rst = 1'b1;
        re1_i = 1'b1; raddr1_i = 5'd9;
        #1;
        check("rst_ready_rd1", rdata1_o, 32'h0);
        step();
        check("rst_ready_busy", 32'(busy_o), 32'h1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("midclear_busy_c%0d", i), 32'(busy_o), 32'h1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_clear("clear2", 1'b0, n);
        check("clear2_busy_cycles", n, 31);
        re1_i = 1'b1; raddr1_i = 5'd9;
        re2_i = 1'b1; raddr2_i = 5'd20;
        #1;
        check("after_reclear_r9", rdata1_o, 32'h0);
        check("after_reclear_r20", rdata2_o, 32'h0);
        raddr1_i = 5'd5; raddr2_i = 5'd7;
        #1;
        check("after_reclear_r5", rdata1_o, 32'h0);
        check("after_reclear_r7", rdata2_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
